// File: rtl/jt12_wr_pkg.sv
// Shared definitions for the FM host-write scheduler: register address codes,
// strobe indices, FSM encoding, queue entry width and the register decoder.
package jt12_wr_pkg;

   localparam int ENTRY_W = 17;

   localparam logic [7:0] REG_KON  = 8'h28;
   localparam logic [3:0] NIB_DT1  = 4'h3;
   localparam logic [3:0] NIB_TL   = 4'h4;
   localparam logic [3:0] NIB_KSAR = 4'h5;
   localparam logic [3:0] NIB_AMDR = 4'h6;
   localparam logic [3:0] NIB_SR   = 4'h7;
   localparam logic [3:0] NIB_SLRR = 4'h8;
   localparam logic [3:0] NIB_SSG  = 4'h9;
   localparam logic [3:0] NIB_A    = 4'hA;
   localparam logic [3:0] NIB_B    = 4'hB;

   localparam int UP_W     = 11;
   localparam int UP_KEYON = 0;
   localparam int UP_DT1   = 1;
   localparam int UP_TL    = 2;
   localparam int UP_KSAR  = 3;
   localparam int UP_AMDR  = 4;
   localparam int UP_SR    = 5;
   localparam int UP_SLRR  = 6;
   localparam int UP_SSG   = 7;
   localparam int UP_FNUM  = 8;
   localparam int UP_ALG   = 9;
   localparam int UP_PMS   = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_HOLD = 2'd2
   } wr_state_t;

   typedef struct packed {
      logic [UP_W-1:0] up;
      logic            latch;
   } wr_dec_t;

   // Key-on is part-independent; everything else needs a real channel slot.
   function automatic wr_dec_t wr_decode(input logic part, input logic [7:0] rg, input logic ch3);
      wr_dec_t d;
      d.up    = '0;
      d.latch = 1'b0;
      if (rg == REG_KON) begin
         d.up[UP_KEYON] = 1'b1;
      end else if ((rg[1:0] == 2'd3) || (part && ch3)) begin
         d.up = '0;
      end else begin
         case (rg[7:4])
            NIB_DT1:  d.up[UP_DT1]  = 1'b1;
            NIB_TL:   d.up[UP_TL]   = 1'b1;
            NIB_KSAR: d.up[UP_KSAR] = 1'b1;
            NIB_AMDR: d.up[UP_AMDR] = 1'b1;
            NIB_SR:   d.up[UP_SR]   = 1'b1;
            NIB_SLRR: d.up[UP_SLRR] = 1'b1;
            NIB_SSG:  d.up[UP_SSG]  = 1'b1;
            NIB_A: begin
               case (rg[3:2])
                  2'd0:    d.up[UP_FNUM] = 1'b1;
                  2'd1:    d.latch       = 1'b1;
                  default: d.up          = '0;
               endcase
            end
            NIB_B: begin
               case (rg[3:2])
                  2'd0:    d.up[UP_ALG] = 1'b1;
                  2'd1:    d.up[UP_PMS] = 1'b1;
                  default: d.up         = '0;
               endcase
            end
            default: d.up = '0;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/jt12_wr_fifo.sv
// Host-write queue. With JT12_WRFIFO_EN defined it is a 2**AW-entry circular
// FIFO; otherwise a single holding register. Output is show-ahead.
module jt12_wr_fifo
   import jt12_wr_pkg::*;
#(
   parameter int AW = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic [ENTRY_W-1:0] din,
   output logic [ENTRY_W-1:0] dout,
   output logic               full,
   output logic               empty
);

   logic push_ok_s;
   logic pop_ok_s;

   // Fullness is judged on the pre-edge state, so push+pop while full still drops.
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;

`ifdef JT12_WRFIFO_EN
   localparam int DEPTH = 2**AW;

   logic [ENTRY_W-1:0] mem_r [DEPTH];
   logic [AW-1:0]      wr_ptr_r;
   logic [AW-1:0]      rd_ptr_r;
   logic [AW:0]        cnt_r;

   // Storage, wrapping pointers and occupancy count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
            2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   assign dout  = mem_r[rd_ptr_r];
   assign full  = (cnt_r == (AW+1)'(DEPTH));
   assign empty = (cnt_r == '0);
`else
   logic               valid_r;
   logic [ENTRY_W-1:0] data_r;
   logic               unused_aw_s;

   assign unused_aw_s = ^AW;

   // Single holding register: occupied from accepted push until pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r <= 1'b0;
         data_r  <= '0;
      end else if (push_ok_s) begin
         valid_r <= 1'b1;
         data_r  <= din;
      end else if (pop_ok_s) begin
         valid_r <= 1'b0;
      end
   end

   assign dout  = data_r;
   assign full  = valid_r;
   assign empty = ~valid_r;
`endif

endmodule

// File: rtl/jt12_wr_sched.sv
// FM host-write scheduler: queues CPU writes and turns each into an update strobe
// held for one slot rotation. Queue depth is selected by JT12_WRFIFO_EN.
module jt12_wr_sched
   import jt12_wr_pkg::*;
#(
   parameter int NUM_CH  = 6,
   parameter int FIFO_AW = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_en,
   input  logic       cpu_wr,
   input  logic [1:0] cpu_addr,
   input  logic [7:0] cpu_din,
   output logic       busy,
   output logic       wr_lost,
   output logic [2:0] ch_sel,
   output logic [1:0] op_sel,
   output logic [7:0] din,
   output logic       up_keyon,
   output logic       up_dt1,
   output logic       up_tl,
   output logic       up_ks_ar,
   output logic       up_amen_dr,
   output logic       up_sr,
   output logic       up_sl_rr,
   output logic       up_ssgeg,
   output logic       up_fnumlo,
   output logic       up_alg,
   output logic       up_pms,
   output logic [5:0] latch_fnum
);

   localparam int              HOLD_N    = 4 * NUM_CH;
   localparam int              CNT_W     = $clog2(HOLD_N);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_N - 1);
   localparam logic            CH3       = (NUM_CH == 3) ? 1'b1 : 1'b0;

   logic               addr_part_r;
   logic [7:0]         addr_reg_r;
   logic               push_s;
   logic               pop_s;
   logic               full_s;
   logic               empty_s;
   logic [ENTRY_W-1:0] fifo_dout_s;
   logic [ENTRY_W-1:0] entry_r;
   wr_dec_t            dec_s;
   wr_state_t          state_r;
   wr_state_t          state_nx_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [CNT_W-1:0]   cnt_nx_s;
   logic [2:0]         ch_sel_r, ch_sel_nx_s;
   logic [1:0]         op_sel_r, op_sel_nx_s;
   logic [7:0]         din_r, din_nx_s;
   logic [UP_W-1:0]    up_r, up_nx_s;
   logic [5:0]         latch_r, latch_nx_s;
   logic               wr_lost_r;

   assign push_s = cpu_wr & cpu_addr[0];
   assign pop_s  = clk_en & (state_r == ST_IDLE) & ~empty_s;

   jt12_wr_fifo #(.AW(FIFO_AW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .din   ({addr_part_r, addr_reg_r, cpu_din}),
      .dout  (fifo_dout_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // Held address from address-phase writes and the drop indicator.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_part_r <= 1'b0;
         addr_reg_r  <= 8'h00;
         wr_lost_r   <= 1'b0;
      end else begin
         if (cpu_wr && !cpu_addr[0]) begin
            addr_part_r <= cpu_addr[1];
            addr_reg_r  <= cpu_din;
         end
         wr_lost_r <= push_s & full_s;
      end
   end

   // Popped entry is kept locally so the queue slot frees at pop time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) entry_r <= '0;
      else if (pop_s) entry_r <= fifo_dout_s;
   end

   assign dec_s = wr_decode(entry_r[16], entry_r[15:8], CH3);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= ST_IDLE;
      else state_r <= state_nx_s;
   end

   // Next-state logic; only slot-advance cycles move the FSM.
   always_comb begin
      state_nx_s = state_r;
      if (clk_en) begin
         case (state_r)
            ST_IDLE: state_nx_s = empty_s ? ST_IDLE : ST_LOAD;
            ST_LOAD: state_nx_s = (|dec_s.up) ? ST_HOLD : ST_IDLE;
            ST_HOLD: state_nx_s = (cnt_r == HOLD_LAST) ? ST_IDLE : ST_HOLD;
            default: state_nx_s = ST_IDLE;
         endcase
      end else begin
         state_nx_s = state_r;
      end
   end

   // Output next values: drive on LOAD, release the strobe at the end of HOLD.
   always_comb begin
      cnt_nx_s    = cnt_r;
      ch_sel_nx_s = ch_sel_r;
      op_sel_nx_s = op_sel_r;
      din_nx_s    = din_r;
      up_nx_s     = up_r;
      latch_nx_s  = latch_r;
      if (clk_en) begin
         case (state_r)
            ST_LOAD: begin
               if (entry_r[15:8] == REG_KON) begin
                  ch_sel_nx_s = 3'd0;
                  op_sel_nx_s = 2'd0;
               end else begin
                  ch_sel_nx_s = {entry_r[16], entry_r[9:8]};
                  op_sel_nx_s = entry_r[11:10];
               end
               din_nx_s = entry_r[7:0];
               up_nx_s  = dec_s.up;
               cnt_nx_s = '0;
               if (dec_s.latch) latch_nx_s = entry_r[5:0];
               else latch_nx_s = latch_r;
            end
            ST_HOLD: begin
               if (cnt_r == HOLD_LAST) begin
                  up_nx_s  = '0;
                  cnt_nx_s = '0;
               end else begin
                  cnt_nx_s = cnt_r + CNT_W'(1);
               end
            end
            default: cnt_nx_s = cnt_r;
         endcase
      end else begin
         cnt_nx_s = cnt_r;
      end
   end

   // Registered outputs and hold counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r    <= '0;
         ch_sel_r <= 3'd0;
         op_sel_r <= 2'd0;
         din_r    <= 8'h00;
         up_r     <= '0;
         latch_r  <= 6'd0;
      end else begin
         cnt_r    <= cnt_nx_s;
         ch_sel_r <= ch_sel_nx_s;
         op_sel_r <= op_sel_nx_s;
         din_r    <= din_nx_s;
         up_r     <= up_nx_s;
         latch_r  <= latch_nx_s;
      end
   end

   assign busy       = full_s;
   assign wr_lost    = wr_lost_r;
   assign ch_sel     = ch_sel_r;
   assign op_sel     = op_sel_r;
   assign din        = din_r;
   assign latch_fnum = latch_r;
   assign up_keyon   = up_r[UP_KEYON];
   assign up_dt1     = up_r[UP_DT1];
   assign up_tl      = up_r[UP_TL];
   assign up_ks_ar   = up_r[UP_KSAR];
   assign up_amen_dr = up_r[UP_AMDR];
   assign up_sr      = up_r[UP_SR];
   assign up_sl_rr   = up_r[UP_SLRR];
   assign up_ssgeg   = up_r[UP_SSG];
   assign up_fnumlo  = up_r[UP_FNUM];
   assign up_alg     = up_r[UP_ALG];
   assign up_pms     = up_r[UP_PMS];

endmodule
